param_commit_scheduler: RTL

Shares the single-port parameter RAM between DSP-core coefficient reads and host (CPU) parameter updates. Host writes are buffered in a FIFO as atomic groups, such as one biquad's five coefficients, each ending with a `last` flag. Only complete groups are committed, and only inside the inter-frame window. A `frame_hold` output prevents the DSP from ever seeing a partially updated group.

---
 rtl/param_commit_scheduler_pkg.sv | 20 ++
 rtl/param_commit_scheduler_if.sv | 31 +++
 rtl/param_commit_scheduler_fifo.sv | 49 ++++
 rtl/param_commit_scheduler.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/param_commit_scheduler_pkg.sv
// Shared types for the parameter-RAM commit scheduler.
// Default widths, the buffered update word and the commit FSM states.
package dsp_param_pkg;

    localparam int PARAM_WIDTH_DEF      = 36;
    localparam int PARAM_ADDR_WIDTH_DEF = 10;
    localparam int FIFO_DEPTH_DEF       = 16;

    typedef struct packed {
        logic [PARAM_ADDR_WIDTH_DEF-1:0] addr;
        logic [PARAM_WIDTH_DEF-1:0]      data;
        logic                            last;
    } param_update_t;

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } commit_state_t;

endpackage

// File: rtl/param_commit_scheduler_if.sv
// Host parameter-update handshake (valid/ready with group-closing last flag).
interface param_commit_scheduler_if
    import dsp_param_pkg::*;
#(
    parameter int AW = PARAM_ADDR_WIDTH_DEF,
    parameter int DW = PARAM_WIDTH_DEF
);

    logic          host_wr_valid;
    logic          host_wr_ready;
    logic [AW-1:0] host_wr_addr;
    logic [DW-1:0] host_wr_data;
    logic          host_wr_last;

    modport master (
        output host_wr_valid,
        output host_wr_addr,
        output host_wr_data,
        output host_wr_last,
        input  host_wr_ready
    );

    modport slave (
        input  host_wr_valid,
        input  host_wr_addr,
        input  host_wr_data,
        input  host_wr_last,
        output host_wr_ready
    );

endinterface

// File: rtl/param_commit_scheduler_fifo.sv
// Synchronous FIFO of pending parameter updates with flush.
module param_update_fifo
    import dsp_param_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  param_update_t din,
    output logic          full,
    output logic          empty,
    output param_update_t head
);

    localparam int PW = $clog2(DEPTH);

    param_update_t mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/param_commit_scheduler.sv
// Commits complete host parameter groups into the shared RAM between frames.
// Optional commit counter output enabled by PARAM_COMMIT_COUNT_EN.
module param_commit_scheduler
    import dsp_param_pkg::*;
#(
    parameter int PARAM_WIDTH      = PARAM_WIDTH_DEF,
    parameter int PARAM_ADDR_WIDTH = PARAM_ADDR_WIDTH_DEF,
    parameter int FIFO_DEPTH       = FIFO_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    param_commit_scheduler_if.slave     host,
    input  logic                        frame_done,
    input  logic                        frame_start,
    input  logic                        dsp_rd_en,
    input  logic [PARAM_ADDR_WIDTH-1:0] dsp_rd_addr,
    output logic [PARAM_ADDR_WIDTH-1:0] ram_addr,
    output logic                        ram_rd_en,
    output logic                        ram_wr_en,
    output logic [PARAM_WIDTH-1:0]      ram_wr_data,
    output logic                        frame_hold,
    input  logic                        err_clr,
    output logic                        overflow_err,
    output logic                        tear_err
`ifdef PARAM_COMMIT_COUNT_EN
    ,
    output logic [15:0]                 commit_count
`endif
);

    localparam int GW = $clog2(FIFO_DEPTH) + 1;

    commit_state_t state;
    commit_state_t state_nxt;
    logic [GW-1:0] groups_pending;
    logic          window;
    logic          window_nxt;
    param_update_t wr_word;
    param_update_t head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          flush;
    logic          acc_last;
    logic          com_last;

    assign host.host_wr_ready = !full;
    assign push     = host.host_wr_valid && !full;
    assign wr_word  = '{addr: host.host_wr_addr,
                        data: host.host_wr_data,
                        last: host.host_wr_last};
    // A full FIFO with no closed group can never drain: drop it.
    assign flush    = full && (groups_pending == '0);
    assign pop      = ram_wr_en;
    assign acc_last = push && host.host_wr_last;
    assign com_last = pop && head.last;
    assign window_nxt = frame_start ? 1'b0 :
                        (frame_done ? 1'b1 : window);

    param_update_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .din     (wr_word),
        .full    (full),
        .empty   (empty),
        .head    (head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            window         <= 1'b0;
            groups_pending <= '0;
        end else begin
            window         <= window_nxt;
            groups_pending <= groups_pending + GW'(acc_last)
                                             - GW'(com_last);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (window && groups_pending != '0)
                    state_nxt = COMMIT;
            end
            COMMIT: begin
                if (com_last &&
                    !(window_nxt && groups_pending != GW'(1)))
                    state_nxt = IDLE;
            end
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    // DSP reads always win the single RAM port.
    always_comb begin
        frame_hold  = (state == COMMIT);
        ram_wr_en   = (state == COMMIT) && !dsp_rd_en && !empty;
        ram_rd_en   = dsp_rd_en;
        ram_addr    = dsp_rd_en ? dsp_rd_addr : head.addr;
        ram_wr_data = head.data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tear_err     <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (frame_start && frame_hold)
                tear_err <= 1'b1;
            else if (err_clr)
                tear_err <= 1'b0;
            if (flush)
                overflow_err <= 1'b1;
            else if (err_clr)
                overflow_err <= 1'b0;
        end
    end

`ifdef PARAM_COMMIT_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            commit_count <= '0;
        else if (err_clr)
            commit_count <= '0;
        else if (com_last)
            commit_count <= commit_count + 16'd1;
    end
`endif

endmodule
